led_breath_monitor: RTL

//  Receive-side checker for the LED breathing/PWM drivers. Samples the 8-bit LED bus and

---
 rtl/led_breath_monitor_if.sv | 45 ++++
 rtl/led_breath_monitor.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/led_breath_monitor_if.sv
// ---------------------------------------------------------------------------
// led_breath_monitor_if
//   Bundles the LED bus being observed together with the measurement results
//   of led_breath_monitor.
//   master : the side that drives the LED bus and frame_sync and reads results
//            (LED driver model / testbench).
//   slave  : the monitor itself. It reads led_in/frame_sync and drives results.
//   Signals:
//     led_in      8       LED bus, synchronous to clk
//     frame_sync  1       restart window alignment
//     duty        DUTY_W  on-cycles in the last completed window
//     duty_valid  1       one-cycle pulse when the window results update
//     led_idx     3       index of the single lit LED
//     idx_valid   1       exactly one distinct LED bit seen
//     multi_err   1       more than one distinct LED bit seen
//     trend       2       00 flat/none, 01 rising, 10 falling
//     peak        1       rising->falling turn pulse
//     trough      1       falling->rising turn pulse
// ---------------------------------------------------------------------------
interface led_breath_monitor_if #(
  parameter int WIN_LEN = 16
);
  localparam int DUTY_W = $clog2(WIN_LEN) + 1;

  logic [7:0]        led_in;
  logic              frame_sync;
  logic [DUTY_W-1:0] duty;
  logic              duty_valid;
  logic [2:0]        led_idx;
  logic              idx_valid;
  logic              multi_err;
  logic [1:0]        trend;
  logic              peak;
  logic              trough;

  modport master (
    output led_in, frame_sync,
    input  duty, duty_valid, led_idx, idx_valid, multi_err, trend, peak, trough
  );

  modport slave (
    input  led_in, frame_sync,
    output duty, duty_valid, led_idx, idx_valid, multi_err, trend, peak, trough
  );
endinterface

// File: rtl/led_breath_monitor.sv
// ---------------------------------------------------------------------------
// led_breath_monitor
//   Receive-side checker for the LED breathing/PWM drivers. Counts how many
//   cycles of each WIN_LEN-cycle window have any LED lit (duty), decodes which
//   single LED was active, flags windows where more than one LED lit, and
//   follows the duty trend window to window to report breath peaks/troughs.
//   Purely an observer: it never drives the LEDs.
//   Ports:
//     clk  - system clock
//     rst  - asynchronous reset, active-high
//     mon  - led_breath_monitor_if.slave (LED bus in, measurement results out)
// ---------------------------------------------------------------------------
module led_breath_monitor #(
  parameter int WIN_LEN = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  led_breath_monitor_if.slave   mon
);
  localparam int CNT_W  = $clog2(WIN_LEN);
  localparam int DUTY_W = CNT_W + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIN_LEN - 1);

  typedef enum logic [1:0] {S_INIT, S_FLAT, S_RISE, S_FALL} state_t;

  // window accumulators
  logic [CNT_W-1:0]  win_cnt;
  logic [DUTY_W-1:0] on_cnt;
  logic [7:0]        or_acc;
  logic              multi;

  // values including the current sample
  logic              win_end, restart;
  logic [DUTY_W-1:0] on_fin;
  logic [7:0]        or_fin;
  logic              multi_fin, or_onehot, or_multi;
  logic [2:0]        or_idx;

  // result registers
  logic [DUTY_W-1:0] duty_r;
  logic              duty_valid_r;
  logic [2:0]        led_idx_r;
  logic              idx_valid_r, multi_err_r;

  // trend tracking
  state_t            state, state_nxt;
  logic [DUTY_W-1:0] prev_duty;
  logic              peak_r, trough_r, peak_nxt, trough_nxt;

  // A sync landing on the last window slot is ignored: that window completes
  // normally and the wrap to slot 0 already realigns everything.
  always_comb begin
    win_end   = (win_cnt == LAST);
    restart   = mon.frame_sync && !win_end;
    // on a restart the current sample becomes slot 0 of the new window
    on_fin    = (restart ? '0 : on_cnt) + DUTY_W'(|mon.led_in);
    or_fin    = (restart ? 8'h00 : or_acc) | mon.led_in;
    multi_fin = (restart ? 1'b0 : multi) |
                ((mon.led_in & (mon.led_in - 8'd1)) != 8'h00);
    // x & (x-1) clears the lowest set bit: zero result means at most one bit
    or_onehot = (or_fin != 8'h00) && ((or_fin & (or_fin - 8'd1)) == 8'h00);
    or_multi  = (or_fin != 8'h00) && !or_onehot;
    or_idx    = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (or_fin[i]) or_idx = 3'(i);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_cnt <= '0;
      on_cnt  <= '0;
      or_acc  <= 8'h00;
      multi   <= 1'b0;
    end else if (win_end) begin
      win_cnt <= '0;
      on_cnt  <= '0;
      or_acc  <= 8'h00;
      multi   <= 1'b0;
    end else begin
      win_cnt <= restart ? CNT_W'(1) : win_cnt + CNT_W'(1);
      on_cnt  <= on_fin;
      or_acc  <= or_fin;
      multi   <= multi_fin;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      duty_r       <= '0;
      duty_valid_r <= 1'b0;
      led_idx_r    <= 3'd0;
      idx_valid_r  <= 1'b0;
      multi_err_r  <= 1'b0;
    end else begin
      duty_valid_r <= win_end;
      if (win_end) begin
        duty_r      <= on_fin;
        // keep the last good index when the window is dark or ambiguous
        if (or_onehot) led_idx_r <= or_idx;
        idx_valid_r <= or_onehot && !multi_fin;
        multi_err_r <= or_multi || multi_fin;
      end
    end
  end

  // Trend FSM. The rise/fall states double as the last nonflat direction, so
  // an equal duty simply holds the state and keeps that direction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_INIT;
      prev_duty <= '0;
      peak_r    <= 1'b0;
      trough_r  <= 1'b0;
    end else begin
      state    <= state_nxt;
      peak_r   <= peak_nxt;
      trough_r <= trough_nxt;
      if (win_end) prev_duty <= on_fin;
    end
  end

  always_comb begin
    state_nxt  = state;
    peak_nxt   = 1'b0;
    trough_nxt = 1'b0;
    if (win_end) begin
      case (state)
        S_INIT: state_nxt = S_FLAT;
        default: begin
          if (on_fin > prev_duty) begin
            state_nxt  = S_RISE;
            trough_nxt = (state == S_FALL);
          end else if (on_fin < prev_duty) begin
            state_nxt = S_FALL;
            peak_nxt  = (state == S_RISE);
          end
        end
      endcase
    end
  end

  assign mon.duty       = duty_r;
  assign mon.duty_valid = duty_valid_r;
  assign mon.led_idx    = led_idx_r;
  assign mon.idx_valid  = idx_valid_r;
  assign mon.multi_err  = multi_err_r;
  assign mon.trend      = (state == S_RISE) ? 2'b01 :
                          (state == S_FALL) ? 2'b10 : 2'b00;
  assign mon.peak       = peak_r;
  assign mon.trough     = trough_r;

  // turn pulses only ever accompany a window result
  a_pulse_align: assert property (@(posedge clk) disable iff (rst)
    (peak_r || trough_r) |-> duty_valid_r);
  a_no_both: assert property (@(posedge clk) disable iff (rst)
    !(peak_r && trough_r));

endmodule
